// File: rtl/io_fifo.sv
// First-word-fall-through input FIFO; a push into an empty FIFO shows on dout after that edge.
// Pushes while full are dropped and set the sticky ovf, unless the same edge also pops.
module io_fifo #(
   parameter int NUBITS = 16,
   parameter int FDEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [NUBITS-1:0] din,
   output logic [NUBITS-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic              ovf
);
   localparam int AW = $clog2(FDEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FDEPTH);

   logic [NUBITS-1:0] mem [FDEPTH];
   logic [AW-1:0]     wptr;
   logic [AW-1:0]     rptr;
   logic [CW-1:0]     count;
   logic              do_pop;
   logic              do_push;

   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   // a pop on the same edge frees the slot, so a push while full is still accepted
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + AW'(1);
         if (do_pop)  rptr <= rptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
         if (push && !do_push) ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end
endmodule

// File: rtl/io_responder.sv
// I/O port responder: OUT writes land in port registers with a 1-cycle strobe; INN reads pop per-port FIFOs.
// Reads never stall (empty returns 0); external pushes into a full FIFO drop and flag ovf; itr is one pulse per arrival burst.
module io_responder #(
   parameter int                      NUBITS = 16,
   parameter int                      NBIOIN = 2,
   parameter int                      NBIOOU = 2,
   parameter int                      FDEPTH = 4,
   parameter logic [(2**NBIOIN)-1:0]  ITRMSK = '1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [NUBITS-1:0]                  io_out,
   input  logic [NBIOOU-1:0]                  addr_out,
   input  logic                               out_en,
   input  logic                               req_in,
   input  logic [NBIOIN-1:0]                  addr_in,
   output logic [NUBITS-1:0]                  io_in,
   output logic                               itr,
   output logic [(2**NBIOOU)*NUBITS-1:0]      out_data,
   output logic [(2**NBIOOU)-1:0]             out_stb,
   input  logic                               ext_wr,
   input  logic [NBIOIN-1:0]                  ext_addr,
   input  logic [NUBITS-1:0]                  ext_data,
   output logic [(2**NBIOIN)-1:0]             ext_full,
   output logic [(2**NBIOIN)-1:0]             ovf
);
   localparam int NIN = 2**NBIOIN;
   localparam int NOU = 2**NBIOOU;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [NUBITS-1:0] fifo_dout [NIN];
   logic [NIN-1:0]    fifo_empty;
   logic [NIN-1:0]    push_vec;
   logic [NIN-1:0]    pop_vec;
   logic              arrival;

   genvar k;
   generate
      for (k = 0; k < NIN; k++) begin : g_in
         assign push_vec[k] = ext_wr && (ext_addr == NBIOIN'(k));
         assign pop_vec[k]  = req_in && (addr_in == NBIOIN'(k));

         io_fifo #(
            .NUBITS (NUBITS),
            .FDEPTH (FDEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_vec[k]),
            .pop   (pop_vec[k]),
            .din   (ext_data),
            .dout  (fifo_dout[k]),
            .empty (fifo_empty[k]),
            .full  (ext_full[k]),
            .ovf   (ovf[k])
         );
      end
   endgenerate

   assign io_in = fifo_dout[addr_in];

   // a push into an empty FIFO is always accepted, so this is exactly an empty->non-empty edge
   assign arrival = |(fifo_empty & push_vec & ITRMSK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= '0;
         out_stb  <= '0;
      end else begin
         for (int p = 0; p < NOU; p++) begin
            out_stb[p] <= out_en && (addr_out == NBIOOU'(p));
            if (out_en && (addr_out == NBIOOU'(p)))
               out_data[p*NUBITS +: NUBITS] <= io_out;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         itr   <= 1'b0;
      end else begin
         state <= state_nxt;
         itr   <= (state == PULSE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arrival) state_nxt = PULSE;
         PULSE:   state_nxt = WAIT;
         WAIT:    if (req_in) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule
